// File: rtl/fp_add_normaliser_pipe_pkg.sv
// rtl/fp_add_normaliser_pipe_pkg.sv - shared constants and types for the post-add normaliser
//
// Purpose: default datapath widths, the all-ones exponent helper, the exception
// flag bundle and the default-width stage payload layout.
package fp_norm_pkg;

  localparam int EXP_W_DEF = 8;
  localparam int MAN_W_DEF = 23;

  // All-ones exponent encodes infinity.
  function automatic int exp_max(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

  localparam int EXP_MAX  = exp_max(EXP_W_DEF);
  localparam int LZ_W_DEF = $clog2(MAN_W_DEF + 2);

  typedef struct packed {
    logic zero;
    logic of;
    logic uf;
  } norm_flags_t;

  // Stage-1 payload at the default widths; the top builds the same layout
  // from its own parameters.
  typedef struct packed {
    logic                   s;
    logic [EXP_W_DEF-1:0]   e;
    logic [MAN_W_DEF+1:0]   m;
    logic [LZ_W_DEF-1:0]    lz;
  } norm_payload_t;

endpackage

// File: rtl/fp_add_normaliser_pipe_if.sv
// rtl/fp_add_normaliser_pipe_if.sv - input/output beat bundle of the normaliser
//
// Purpose: groups the input handshake + operand and the output handshake + result.
// Ports (signals): in_valid/in_ready/in_s/in_e/in_m, out_valid/out_ready/out_s/
// out_e/out_m/out_zero/out_of/out_uf.
// master: the side that produces input beats and consumes results.
// slave : the normaliser itself.
interface fp_add_normaliser_pipe_if
  import fp_norm_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
);

  logic               in_valid;
  logic               in_ready;
  logic               in_s;
  logic [EXP_W-1:0]   in_e;
  logic [MAN_W+1:0]   in_m;

  logic               out_valid;
  logic               out_ready;
  logic               out_s;
  logic [EXP_W-1:0]   out_e;
  logic [MAN_W+1:0]   out_m;
  logic               out_zero;
  logic               out_of;
  logic               out_uf;

  modport master (
    output in_valid, in_s, in_e, in_m, out_ready,
    input  in_ready, out_valid, out_s, out_e, out_m, out_zero, out_of, out_uf
  );

  modport slave (
    input  in_valid, in_s, in_e, in_m, out_ready,
    output in_ready, out_valid, out_s, out_e, out_m, out_zero, out_of, out_uf
  );

endinterface

// File: rtl/fp_add_normaliser_pipe_lzc.sv
// rtl/fp_add_normaliser_pipe_lzc.sv - parametrised leading-zero counter
//
// Purpose: counts leading zeros of d_i from its MSB; returns W for all-zero input.
// Ports: d_i (W bits) in, cnt_o ($clog2(W+1) bits) out.
module lzc #(
  parameter  int W  = 24,
  localparam int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  d_i,
  output logic [CW-1:0] cnt_o
);

  // Ascending scan: the highest set bit is the last one to write cnt_o.
  always_comb begin
    cnt_o = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (d_i[i]) begin
        cnt_o = CW'(W - 1 - i);
      end
    end
  end

endmodule

// File: rtl/fp_add_normaliser_pipe.sv
// rtl/fp_add_normaliser_pipe.sv - two-stage post-addition normaliser with backpressure
//
// Purpose: takes a raw sum mantissa (carry, hidden, fraction) and exponent, returns
// a normalised mantissa/exponent with zero, overflow and underflow flags.
// Ports: clk, rst (sync, active-high), bus (slave side of fp_add_normaliser_pipe_if).
// S1 registers the operand plus its leading-zero count; S2 registers the result.
module fp_add_normaliser_pipe
  import fp_norm_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  fp_add_normaliser_pipe_if.slave   bus
);

  localparam int MW      = MAN_W + 2;
  localparam int LZ_W    = $clog2(MAN_W + 2);
  localparam int EXP_ALL = exp_max(EXP_W);

  typedef struct packed {
    logic              s;
    logic [EXP_W-1:0]  e;
    logic [MW-1:0]     m;
    logic [LZ_W-1:0]   lz;
  } payload_t;

  logic              adv1, adv2;
  logic [LZ_W-1:0]   lz_w;

  logic              s1_valid_q, s1_valid_d;
  payload_t          s1_q, s1_d;

  logic              out_valid_q, out_valid_d;
  logic              out_s_q, out_s_d;
  logic [EXP_W-1:0]  out_e_q, out_e_d;
  logic [MW-1:0]     out_m_q, out_m_d;
  norm_flags_t       flags_q, flags_d;

  logic [EXP_W-1:0]  nrm_e;
  logic [MW-1:0]     nrm_m;
  norm_flags_t       nrm_flags;
  logic [EXP_W:0]    e_ext, e_inc, lz_ext;

  // A stage moves when the stage after it is empty or moving; S2 drains and
  // S1 refills in the same cycle, so there is no bubble.
  assign adv2        = !out_valid_q || bus.out_ready;
  assign adv1        = !s1_valid_q || adv2;
  assign bus.in_ready = adv1;

  lzc #(.W(MAN_W + 1)) u_lzc (
    .d_i   (bus.in_m[MAN_W:0]),
    .cnt_o (lz_w)
  );

  // S2 normalisation. Exponent compares run one bit wider so nothing wraps.
  always_comb begin
    e_ext     = {1'b0, s1_q.e};
    e_inc     = e_ext + (EXP_W+1)'(1);
    lz_ext    = (EXP_W+1)'(s1_q.lz);
    nrm_e     = s1_q.e;
    nrm_m     = s1_q.m;
    nrm_flags = '0;
    if (s1_q.m == '0) begin
      nrm_e          = '0;
      nrm_m          = '0;
      nrm_flags.zero = 1'b1;
    end else if (s1_q.m[MW-1]) begin
      // Carry out: shift right one, truncating the LSB.
      if (e_inc >= (EXP_W+1)'(EXP_ALL)) begin
        nrm_e        = '1;
        nrm_m        = '0;
        nrm_flags.of = 1'b1;
      end else begin
        nrm_e = e_inc[EXP_W-1:0];
        nrm_m = s1_q.m >> 1;
      end
    end else if (!s1_q.m[MAN_W]) begin
      // Leading zeros below the hidden position: shift up if the exponent allows.
      if (e_ext > lz_ext) begin
        nrm_e = s1_q.e - EXP_W'(s1_q.lz);
        nrm_m = s1_q.m << s1_q.lz;
      end else begin
        nrm_e          = '0;
        nrm_m          = '0;
        nrm_flags.uf   = 1'b1;
        nrm_flags.zero = 1'b1;
      end
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_d        = s1_q;
    out_valid_d = out_valid_q;
    out_s_d     = out_s_q;
    out_e_d     = out_e_q;
    out_m_d     = out_m_q;
    flags_d     = flags_q;
    if (adv1) begin
      s1_valid_d = bus.in_valid;
      s1_d.s     = bus.in_s;
      s1_d.e     = bus.in_e;
      s1_d.m     = bus.in_m;
      s1_d.lz    = lz_w;
    end
    if (adv2) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_s_d = s1_q.s;
        out_e_d = nrm_e;
        out_m_d = nrm_m;
        flags_d = nrm_flags;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      out_s_q     <= 1'b0;
      out_e_q     <= '0;
      out_m_q     <= '0;
      flags_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      out_valid_q <= out_valid_d;
      out_s_q     <= out_s_d;
      out_e_q     <= out_e_d;
      out_m_q     <= out_m_d;
      flags_q     <= flags_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_s     = out_s_q;
  assign bus.out_e     = out_e_q;
  assign bus.out_m     = out_m_q;
  assign bus.out_zero  = flags_q.zero;
  assign bus.out_of    = flags_q.of;
  assign bus.out_uf    = flags_q.uf;

endmodule

// File: tb/tb_fp_add_normaliser_pipe.sv
// tb/tb_fp_add_normaliser_pipe.sv - self-checking bench for fp_add_normaliser_pipe
module tb_fp_add_normaliser_pipe;

  localparam int EW = 8;
  localparam int MW = 23;
  localparam int BW = MW + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_add_normaliser_pipe_if #(.EXP_W(EW), .MAN_W(MW)) bus ();

  fp_add_normaliser_pipe #(.EXP_W(EW), .MAN_W(MW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic           s;
    logic [EW-1:0]  e;
    logic [BW-1:0]  m;
    logic           zero;
    logic           of;
    logic           uf;
  } res_t;

  res_t  exp_q[$];
  int    checks = 0;
  int    failures = 0;
  logic  in_fire = 1'b0;
  int    out_count = 0;
  logic  stall_prev = 1'b0;
  res_t  stall_snap = '0;
  int    sent, stalled, got0, acc;
  logic [EW-1:0] bp_e [8];
  logic [BW-1:0] bp_m [8];

  // Reference: place the leading one at the hidden position and move the
  // exponent by the same distance, then apply the range limits.
  function automatic res_t ref_model(input logic s, input logic [EW-1:0] e, input logic [BW-1:0] m);
    res_t r;
    int   msb;
    int   ne;
    r   = '0;
    r.s = s;
    if (m == '0) begin
      r.zero = 1'b1;
    end else begin
      msb = 0;
      for (int i = 0; i < BW; i++) if (m[i]) msb = i;
      ne = int'(e) + msb - MW;
      if (msb == MW) begin
        r.e = e;
        r.m = m;
      end else if (msb == MW + 1) begin
        if (ne >= (1 << EW) - 1) begin
          r.e  = '1;
          r.of = 1'b1;
        end else begin
          r.e = EW'(ne);
          r.m = m >> 1;
        end
      end else if (ne <= 0) begin
        r.zero = 1'b1;
        r.uf   = 1'b1;
      end else begin
        r.e = EW'(ne);
        r.m = m << (MW - msb);
      end
    end
    return r;
  endfunction

  function automatic logic [BW-1:0] rand_m();
    logic [31:0] r;
    int          k;
    r = $urandom;
    k = $urandom_range(0, 31);
    if ($urandom_range(0, 15) == 0) return '0;
    return BW'(r >> k);
  endfunction

  function automatic logic [EW-1:0] rand_e();
    case ($urandom_range(0, 7))
      0:       return 8'h00;
      1:       return 8'h01;
      2:       return 8'hFE;
      3:       return 8'hFF;
      default: return EW'($urandom);
    endcase
  endfunction

  function automatic res_t observed();
    res_t r;
    r.s    = bus.out_s;
    r.e    = bus.out_e;
    r.m    = bus.out_m;
    r.zero = bus.out_zero;
    r.of   = bus.out_of;
    r.uf   = bus.out_uf;
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Called at the falling edge: scoreboard, stall stability, input capture.
  task automatic monitor();
    res_t cur;
    res_t ev;
    cur     = observed();
    in_fire = 1'b0;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", 64'(bus.out_valid), 64'(1));
        check("stall_hold", 64'(cur), 64'(stall_snap));
      end
      if (bus.out_valid && bus.out_ready) begin
        out_count++;
        check("sb_nonempty", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          ev = exp_q.pop_front();
          check("sb_result", 64'(cur), 64'(ev));
        end
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      stall_snap = cur;
      if (bus.in_valid && bus.in_ready) begin
        in_fire = 1'b1;
        exp_q.push_back(ref_model(bus.in_s, bus.in_e, bus.in_m));
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string tag, input logic s, input logic [EW-1:0] e,
                          input logic [BW-1:0] m, input logic [EW-1:0] xe,
                          input logic [BW-1:0] xm, input logic [2:0] xflags);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_s      = s;
    bus.in_e      = e;
    bus.in_m      = m;
    tick();
    bus.in_valid  = 1'b0;
    @(negedge clk);
    check({tag, "_lat1_valid"}, 64'(bus.out_valid), 64'(0));
    monitor();
    @(posedge clk);
    #1;
    @(negedge clk);
    check({tag, "_valid"}, 64'(bus.out_valid), 64'(1));
    check({tag, "_s"}, 64'(bus.out_s), 64'(s));
    check({tag, "_e"}, 64'(bus.out_e), 64'(xe));
    check({tag, "_m"}, 64'(bus.out_m), 64'(xm));
    check({tag, "_flags"}, 64'({bus.out_zero, bus.out_of, bus.out_uf}), 64'(xflags));
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 64'(bus.out_valid), 64'(0));
    check({tag, "_data"}, 64'(observed()), 64'(0));
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'(1));
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_s      = 1'b0;
    bus.in_e      = '0;
    bus.in_m      = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle("reset");
    @(posedge clk);
    #1;

    // Directed cases: {zero, of, uf}
    directed("pass",     1'b0, 8'h80, 25'h0800000, 8'h80, 25'h0800000, 3'b000);
    directed("carry",    1'b1, 8'h80, 25'h1000001, 8'h81, 25'h0800000, 3'b000);
    directed("deep",     1'b0, 8'h80, 25'h0000001, 8'h69, 25'h0800000, 3'b000);
    directed("zero",     1'b1, 8'h80, 25'h0000000, 8'h00, 25'h0000000, 3'b100);
    directed("overflow", 1'b0, 8'hFE, 25'h1000000, 8'hFF, 25'h0000000, 3'b010);
    directed("underflow",1'b1, 8'h05, 25'h0000100, 8'h00, 25'h0000000, 3'b101);
    directed("boundary", 1'b0, 8'h10, 25'h0000100, 8'h01, 25'h0800000, 3'b000);

    // Backpressure: 8 beats, downstream stalled for the first 5 cycles
    for (int i = 0; i < 8; i++) begin
      bp_e[i] = EW'($urandom_range(32, 200));
      bp_m[i] = rand_m();
    end
    sent          = 0;
    stalled       = 0;
    got0          = out_count;
    bus.out_ready = 1'b0;
    for (int cyc = 0; cyc < 60 && (sent < 8 || exp_q.size() != 0); cyc++) begin
      bus.in_valid = (sent < 8);
      if (sent < 8) begin
        bus.in_s = sent[0];
        bus.in_e = bp_e[sent];
        bus.in_m = bp_m[sent];
      end
      if (stalled == 5) bus.out_ready = 1'b1;
      @(negedge clk);
      if (stalled == 4) begin
        check("bp_in_ready_low", 64'(bus.in_ready), 64'(0));
        check("bp_accepted_two", 64'(sent), 64'(2));
      end
      monitor();
      if (in_fire) sent++;
      if (!bus.out_ready) stalled++;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    check("bp_sent", 64'(sent), 64'(8));
    check("bp_outputs", 64'(out_count - got0), 64'(8));
    check("bp_drained", 64'(exp_q.size()), 64'(0));

    // Reset with two beats in flight
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_s      = 1'b1;
    bus.in_e      = 8'h80;
    bus.in_m      = 25'h1000000;
    tick();
    bus.in_m      = 25'h0000003;
    tick();
    bus.in_valid  = 1'b0;
    rst           = 1'b1;
    tick();
    rst           = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_idle("mid_reset");
    monitor();
    @(posedge clk);
    #1;
    directed("post_reset", 1'b1, 8'h40, 25'h1000000, 8'h41, 25'h0800000, 3'b000);

    // Random traffic with random backpressure
    acc = 0;
    for (int cyc = 0; cyc < 60000 && acc < 10000; cyc++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_s      = 1'($urandom);
      bus.in_e      = rand_e();
      bus.in_m      = rand_m();
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (in_fire) acc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (5) tick();
    check("rand_accepted", 64'(acc), 64'(10000));
    check("rand_drained", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_add_normaliser_pipe.md
# fp_add_normaliser_pipe

Parametrised, pipelined post-addition normaliser for the floating-point adder datapath. It sits between the mantissa adder and the rounding stage. It takes a raw sum mantissa that may carry out or carry many leading zeros, and returns a normalised mantissa, an adjusted exponent and exception flags. It adds carry-out handling, zero detection, overflow/underflow flush and a valid/ready pipeline with backpressure.

## Interface
Parameters:
- EXP_W, 8, exponent width; all-ones exponent = infinity.
- MAN_W, 23, stored fraction width; mantissa buses are MAN_W+2 bits: [MAN_W+1] carry, [MAN_W] hidden, [MAN_W-1:0] fraction.

Ports:
- clk  in  1  single clock; everything on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input beat present.
- in_ready  out  1  block accepts beat this cycle.
- in_s  in  1  sign, passed through.
- in_e  in  EXP_W  pre-normalisation exponent.
- in_m  in  MAN_W+2  raw sum mantissa.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts result.
- out_s  out  1  sign.
- out_e  out  EXP_W  normalised exponent.
- out_m  out  MAN_W+2  normalised mantissa; bit MAN_W+1 always 0.
- out_zero  out  1  result is zero (exact or flushed).
- out_of  out  1  exponent overflow, result forced to infinity.
- out_uf  out  1  exponent underflow, result flushed to zero.

## Operation
- Beat transfers on input when in_valid && in_ready; on output when out_valid && out_ready.
- Stage 1 (S1): registers s, e, m, plus lz = leading-zero count of in_m[MAN_W:0] from the lzc sub-module (lz = MAN_W+1 when all zero).
- Stage 2 (S2): applies first matching rule, in priority order:
  - m == 0: e=0, m=0, zero=1.
  - m[MAN_W+1]=1: m = m>>1 (LSB dropped, truncation), e = in_e+1; if in_e+1 >= 2^EXP_W-1 then e=all-ones, m=0, of=1.
  - m[MAN_W]=1: pass unchanged.
  - otherwise: if in_e > lz, then m = m<<lz and e = in_e-lz; else e=0, m=0, uf=1, zero=1.
- Exponent arithmetic is done in EXP_W+1 bits; no wrap-around permitted.
- Sign passes unchanged in every case, including zero and infinity.
- Flags are mutually exclusive, except uf implies zero.

## Timing
- Latency: 2 cycles from input transfer to out_valid, when there is no backpressure. Throughput is 1 beat/cycle.
- Each stage has a valid bit. adv2 = !s2_valid || out_ready; adv1 = !s1_valid || adv2; in_ready = adv1 (combinational from out_ready).
- A stage holds its data and valid while it is not advancing. Outputs stay stable while out_valid && !out_ready.
- Simultaneous S2 drain and S1 refill in the same cycle is required; there is no bubble.
- Reset: s1_valid=s2_valid=0, and all output registers are 0 (out_valid, out_s, out_e, out_m, out_zero, out_of, out_uf). in_ready is 1 in the first cycle after reset.
- Reset mid-operation discards all in-flight beats. No output transfer occurs in the reset cycle.

## Structure
- Package fp_norm_pkg holds:
  - default EXP_W/MAN_W constants;
  - EXP_MAX = 2^EXP_W-1;
  - a flags typedef {zero, of, uf};
  - a stage-payload typedef {s, e, m, lz}.
- One sub-module: lzc, a parametrised leading-zero counter. Its width is W, its output is $clog2(W+1) bits, and it returns W for all-zero input. It is instanced in S1.
- S2 shift/adjust is inline. Target size is 150-250 lines of RTL.

## Test plan
With EXP_W=8, MAN_W=23, out_ready=1 unless stated:
- Pass and carry: in_e=0x80, in_m=0x0800000 -> 2 cycles later out_e=0x80, out_m=0x0800000, no flags. Then in_m=0x1000001 -> out_e=0x81, out_m=0x0800000.
- Deep left shift and zero: in_e=0x80, in_m=0x0000001 -> out_e=0x69, out_m=0x0800000. Then in_m=0 -> out_zero=1, out_e=0, out_m=0, out_s = in_s.
- Overflow and underflow:
  - in_e=0xFE, in_m=0x1000000 -> out_of=1, out_e=0xFF, out_m=0.
  - in_e=0x05, in_m=0x0000100 (lz=15) -> out_uf=1, out_zero=1, out_e=0.
  - Boundary: in_e=0x10, in_m=0x0000100 -> out_e=0x01, no flags.
- Backpressure: stream 8 beats, hold out_ready=0 for 5 cycles. Required response:
  - in_ready drops after 2 beats are accepted;
  - outputs stay stable while stalled;
  - after release, all 8 results emerge in order with none lost or duplicated.
- Reset mid-operation: assert rst with 2 beats in flight -> the next cycle shows out_valid=0, all outputs 0 and in_ready=1. A fresh beat then completes with 2-cycle latency.
- Random: 10k random in_e/in_m beats with random out_ready, checked against a reference model for value and order.
